// File: rtl/dcache_controller_pkg.sv
// Shared types and encodings for the data cache: FSM states, store sizes and load funct3 codes.
// Load/store codes match the ones driven by the control unit and understood by data_memory.
package dcache_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_ALLOCATE,
        ST_UPDATE
    } state_t;

    localparam logic [1:0] SZ_SB = 2'b00;
    localparam logic [1:0] SZ_SH = 2'b01;
    localparam logic [1:0] SZ_SW = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Widens a byte (half=0, value[7:0]) or halfword (half=1) to 32 bits.
    function automatic logic [31:0] extend_load(input logic [15:0] value, input logic half,
                                                input logic signed_ld);
        if (half)
            return signed_ld ? {{16{value[15]}}, value} : {16'b0, value};
        return signed_ld ? {{24{value[7]}}, value[7:0]} : {24'b0, value[7:0]};
    endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and backing-memory-side signals of the data cache.
// slave = the cache itself, master = the CPU/memory environment driving it.
interface dcache_controller_if #(
    parameter int ADDR_W      = 32,
    parameter int BLOCK_BYTES = 16
);
    localparam int BLK_W = ADDR_W - $clog2(BLOCK_BYTES);

    logic [ADDR_W-1:0]        addr;
    logic [31:0]              write_data;
    logic [2:0]               write_ctrl;
    logic [3:0]               read_ctrl;
    logic [31:0]              read_data;
    logic                     busywait;
    logic                     mem_read;
    logic                     mem_write;
    logic [BLK_W-1:0]         mem_addr;
    logic [8*BLOCK_BYTES-1:0] mem_writedata;
    logic [8*BLOCK_BYTES-1:0] mem_readdata;
    logic                     mem_busywait;
    logic [31:0]              stat_hits;
    logic [31:0]              stat_misses;

    modport slave (
        input  addr, write_data, write_ctrl, read_ctrl, mem_readdata, mem_busywait,
        output read_data, busywait, mem_read, mem_write, mem_addr, mem_writedata,
               stat_hits, stat_misses
    );

    modport master (
        output addr, write_data, write_ctrl, read_ctrl, mem_readdata, mem_busywait,
        input  read_data, busywait, mem_read, mem_write, mem_addr, mem_writedata,
               stat_hits, stat_misses
    );
endinterface

// File: rtl/dcache_line_access.sv
// Combinational access into one cache line: load extract with sign/zero extension
// and byte-enable merge of a store into the line.
module dcache_line_access
    import dcache_controller_pkg::*;
#(
    parameter int BLOCK_BYTES = 16
) (
    input  logic [8*BLOCK_BYTES-1:0]         line,
    input  logic [$clog2(BLOCK_BYTES)-1:0]   offset,
    input  logic [2:0]                       funct3,
    input  logic [1:0]                       size,
    input  logic [31:0]                      write_data,
    output logic [31:0]                      load_value,
    output logic [8*BLOCK_BYTES-1:0]         merged_line
);
    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam logic [OFF_W-1:0] HALF_MASK = ~OFF_W'(1);
    localparam logic [OFF_W-1:0] WORD_MASK = ~OFF_W'(3);

    // Unused low offset bits are masked off so sub-word alignment is implied.
    logic [OFF_W-1:0] half_base;
    logic [OFF_W-1:0] word_base;
    logic [7:0]       byte_val;
    logic [15:0]      half_val;
    logic [31:0]      word_val;

    assign half_base = offset & HALF_MASK;
    assign word_base = offset & WORD_MASK;
    assign byte_val  = line[{offset, 3'b000} +: 8];
    assign half_val  = line[{half_base, 3'b000} +: 16];
    assign word_val  = line[{word_base, 3'b000} +: 32];

    always_comb begin
        load_value = '0;
        case (funct3)
            F3_LB:   load_value = extend_load({8'b0, byte_val}, 1'b0, 1'b1);
            F3_LH:   load_value = extend_load(half_val, 1'b1, 1'b1);
            F3_LW:   load_value = word_val;
            F3_LBU:  load_value = extend_load({8'b0, byte_val}, 1'b0, 1'b0);
            F3_LHU:  load_value = extend_load(half_val, 1'b1, 1'b0);
            default: load_value = '0;
        endcase
    end

    for (genvar gi = 0; gi < BLOCK_BYTES; gi++) begin : g_byte
        localparam logic [OFF_W-1:0] BYTE_IDX = OFF_W'(gi);
        logic       be;
        logic [7:0] new_byte;

        always_comb begin
            be       = 1'b0;
            new_byte = write_data[7:0];
            case (size)
                SZ_SB: be = (offset == BYTE_IDX);
                SZ_SH: begin
                    be       = (half_base == (BYTE_IDX & HALF_MASK));
                    new_byte = write_data[8*(gi%2) +: 8];
                end
                SZ_SW: begin
                    be       = (word_base == (BYTE_IDX & WORD_MASK));
                    new_byte = write_data[8*(gi%4) +: 8];
                end
                default: be = 1'b0;
            endcase
        end

        assign merged_line[8*gi +: 8] = be ? new_byte : line[8*gi +: 8];
    end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache with a miss FSM.
// Define DCACHE_STATS_EN to build saturating hit/miss counters; otherwise stats read 0.
module dcache_controller
    import dcache_controller_pkg::*;
#(
    parameter int SETS        = 8,
    parameter int BLOCK_BYTES = 16,
    parameter int ADDR_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    dcache_controller_if.slave bus
);
    localparam int OFF_W  = $clog2(BLOCK_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W = 8 * BLOCK_BYTES;

    state_t              state_reg;
    logic [SETS-1:0]     valid_reg;
    logic [SETS-1:0]     dirty_reg;
    logic [LINE_W-1:0]   data_array [SETS];
    logic [TAG_W-1:0]    tag_array  [SETS];
    logic                mem_read_reg;
    logic                mem_write_reg;
    logic [ADDR_W-OFF_W-1:0] mem_addr_reg;
    logic [LINE_W-1:0]   mem_writedata_reg;
    logic [TAG_W-1:0]    fill_tag_reg;
    logic [IDX_W-1:0]    fill_index_reg;
    logic [LINE_W-1:0]   fill_data_reg;

    logic [OFF_W-1:0]    offset;
    logic [IDX_W-1:0]    index;
    logic [TAG_W-1:0]    tag;
    logic                write_en, read_en, req, idle, hit, miss, write_hit;
    logic [LINE_W-1:0]   cur_line;
    logic [LINE_W-1:0]   merged_line;
    logic [31:0]         load_value;

    assign offset    = bus.addr[OFF_W-1:0];
    assign index     = bus.addr[OFF_W +: IDX_W];
    assign tag       = bus.addr[ADDR_W-1 -: TAG_W];
    assign write_en  = bus.write_ctrl[2];
    assign read_en   = bus.read_ctrl[3];
    assign req       = write_en | read_en;
    assign idle      = (state_reg == ST_IDLE);
    assign hit       = valid_reg[index] && (tag_array[index] == tag);
    assign miss      = idle && req && !hit;
    assign write_hit = idle && write_en && hit;
    assign cur_line  = data_array[index];

    dcache_line_access #(.BLOCK_BYTES(BLOCK_BYTES)) u_line_access (
        .line        (cur_line),
        .offset      (offset),
        .funct3      (bus.read_ctrl[2:0]),
        .size        (bus.write_ctrl[1:0]),
        .write_data  (bus.write_data),
        .load_value  (load_value),
        .merged_line (merged_line)
    );

    // A simultaneous write wins, so the read path is only driven for pure reads.
    assign bus.read_data     = (idle && read_en && !write_en && hit) ? load_value : '0;
    assign bus.busywait      = miss || !idle;
    assign bus.mem_read      = mem_read_reg;
    assign bus.mem_write     = mem_write_reg;
    assign bus.mem_addr      = mem_addr_reg;
    assign bus.mem_writedata = mem_writedata_reg;

    always_ff @(posedge clk) begin
        if (state_reg == ST_UPDATE) begin
            data_array[fill_index_reg] <= fill_data_reg;
            tag_array[fill_index_reg]  <= fill_tag_reg;
        end else if (write_hit) begin
            data_array[index] <= merged_line;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            valid_reg         <= '0;
            dirty_reg         <= '0;
            mem_read_reg      <= 1'b0;
            mem_write_reg     <= 1'b0;
            mem_addr_reg      <= '0;
            mem_writedata_reg <= '0;
            fill_tag_reg      <= '0;
            fill_index_reg    <= '0;
            fill_data_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (write_hit)
                        dirty_reg[index] <= 1'b1;
                    if (miss) begin
                        // Latch the missing block so the fill survives a dropped CPU request.
                        fill_tag_reg   <= tag;
                        fill_index_reg <= index;
                        if (valid_reg[index] && dirty_reg[index]) begin
                            state_reg         <= ST_WRITEBACK;
                            mem_write_reg     <= 1'b1;
                            mem_addr_reg      <= {tag_array[index], index};
                            mem_writedata_reg <= cur_line;
                        end else begin
                            state_reg    <= ST_ALLOCATE;
                            mem_read_reg <= 1'b1;
                            mem_addr_reg <= {tag, index};
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (!bus.mem_busywait) begin
                        state_reg     <= ST_ALLOCATE;
                        mem_write_reg <= 1'b0;
                        mem_read_reg  <= 1'b1;
                        mem_addr_reg  <= {fill_tag_reg, fill_index_reg};
                    end
                end
                ST_ALLOCATE: begin
                    if (!bus.mem_busywait) begin
                        state_reg     <= ST_UPDATE;
                        mem_read_reg  <= 1'b0;
                        fill_data_reg <= bus.mem_readdata;
                    end
                end
                ST_UPDATE: begin
                    valid_reg[fill_index_reg] <= 1'b1;
                    dirty_reg[fill_index_reg] <= 1'b0;
                    state_reg                 <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hits_reg;
    logic [31:0] misses_reg;
    logic        replay_reg;

    // replay_reg marks the first IDLE cycle after a fill; that hit belongs to the miss.
    always_ff @(posedge clk) begin
        if (reset) begin
            hits_reg   <= '0;
            misses_reg <= '0;
            replay_reg <= 1'b0;
        end else begin
            replay_reg <= (state_reg == ST_UPDATE);
            if (idle && req && hit && !replay_reg && (hits_reg != '1))
                hits_reg <= hits_reg + 32'd1;
            if (miss && (misses_reg != '1))
                misses_reg <= misses_reg + 32'd1;
        end
    end

    assign bus.stat_hits   = hits_reg;
    assign bus.stat_misses = misses_reg;
`else
    assign bus.stat_hits   = '0;
    assign bus.stat_misses = '0;
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: flat byte-memory reference model plus a
// per-set directory predicting hit/miss, write-back and busywait length.
module tb_dcache_controller;
    import dcache_controller_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dcache_controller_if #(.ADDR_W(32), .BLOCK_BYTES(16)) bus();

    dcache_controller #(.SETS(8), .BLOCK_BYTES(16), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Backing memory: 64 blocks of 16 bytes, written only by this process.
    logic [127:0] mem_model [64];
    logic         poke_en = 1'b0;
    logic [5:0]   poke_addr = '0;
    logic [127:0] poke_data = '0;
    int           lat_cfg = 0;
    int           wait_left = 0;
    logic         mem_active;

    assign mem_active       = bus.mem_read | bus.mem_write;
    assign bus.mem_busywait = mem_active && (wait_left != 0);
    assign bus.mem_readdata = mem_model[bus.mem_addr[5:0]];

    always @(posedge clk) begin
        if (reset || !mem_active || wait_left == 0) wait_left <= lat_cfg;
        else wait_left <= wait_left - 1;
        if (poke_en) mem_model[poke_addr] <= poke_data;
        else if (!reset && bus.mem_write && !bus.mem_busywait)
            mem_model[bus.mem_addr[5:0]] <= bus.mem_writedata;
    end

    // Reference: architectural byte memory and a directory of what each set holds.
    logic [7:0] ref_mem [1024];
    bit         ref_valid [8];
    bit         ref_dirty [8];
    int         ref_tag   [8];
    int         exp_hits = 0;
    int         exp_misses = 0;

    function automatic logic [127:0] ref_block(input int blk);
        logic [127:0] b;
        for (int i = 0; i < 16; i++) b[8*i +: 8] = ref_mem[blk*16 + i];
        return b;
    endfunction

    function automatic logic [31:0] ref_load(input int a, input logic [2:0] f3);
        int h = a & ~1;
        int w = a & ~3;
        logic [7:0]  b8  = ref_mem[a];
        logic [15:0] h16 = {ref_mem[h+1], ref_mem[h]};
        case (f3)
            3'b000:  return {{24{b8[7]}}, b8};
            3'b001:  return {{16{h16[15]}}, h16};
            3'b010:  return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
            3'b100:  return {24'b0, b8};
            3'b101:  return {16'b0, h16};
            default: return 32'h0;
        endcase
    endfunction

    task automatic clear_directory();
        for (int s = 0; s < 8; s++) begin
            ref_valid[s] = 1'b0;
            ref_dirty[s] = 1'b0;
            ref_tag[s]   = 0;
        end
    endtask

    // Dirty lines are lost on reset, so the architectural state becomes the backing memory.
    task automatic resync_ref();
        logic [127:0] blk;
        for (int i = 0; i < 1024; i++) begin
            blk = mem_model[i/16];
            ref_mem[i] = blk[8*(i%16) +: 8];
        end
    endtask

    task automatic set_block(input int blk, input logic [127:0] d);
        poke_en   = 1'b1;
        poke_addr = blk[5:0];
        poke_data = d;
        for (int i = 0; i < 16; i++) ref_mem[blk*16 + i] = d[8*i +: 8];
        @(posedge clk);
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // One CPU access, started and ended at a negedge. Checks busywait length, memory
    // handshake addresses/data, request stability, and load data against the model.
    task automatic access(input bit wr, input int a, input logic [2:0] code, input logic [31:0] wd);
        int idx = (a >> 4) & 7;
        int tg  = a >> 7;
        int vic, h, w, n, exp_busy;
        bit hit_e, dirty_e, saw_wb, saw_rd, p_mb, p_rd, p_wr;
        logic [27:0] p_addr;
        hit_e    = ref_valid[idx] && (ref_tag[idx] == tg);
        dirty_e  = !hit_e && ref_valid[idx] && ref_dirty[idx];
        vic      = (ref_tag[idx] << 3) | idx;
        exp_busy = hit_e ? 0 : 3 + lat_cfg + (dirty_e ? lat_cfg + 1 : 0);
        if (hit_e) exp_hits++; else exp_misses++;
        bus.addr       = 32'(a);
        bus.write_data = wd;
        bus.write_ctrl = wr ? {1'b1, code[1:0]} : 3'b000;
        bus.read_ctrl  = wr ? 4'b0000 : {1'b1, code};
        n = 0; saw_wb = 0; saw_rd = 0; p_mb = 0; p_rd = 0; p_wr = 0; p_addr = '0;
        #1;
        while (bus.busywait && n < 400) begin
            if (bus.mem_read && bus.mem_write) begin
                errors++;
                $display("FAIL rw_exclusive addr=%h: mem_read and mem_write both 1", a);
            end
            if (p_mb) begin
                checks++;
                if (bus.mem_read !== p_rd || bus.mem_write !== p_wr || bus.mem_addr !== p_addr) begin
                    errors++;
                    $display("FAIL req_stable addr=%h: got rd=%b wr=%b maddr=%h, held rd=%b wr=%b maddr=%h",
                             a, bus.mem_read, bus.mem_write, bus.mem_addr, p_rd, p_wr, p_addr);
                end
            end
            if (bus.mem_write && !saw_wb) begin
                saw_wb = 1;
                checks++;
                if (bus.mem_addr !== 28'(vic) || bus.mem_writedata !== ref_block(vic)) begin
                    errors++;
                    $display("FAIL writeback addr=%h: got maddr=%h data=%h, want maddr=%h data=%h",
                             a, bus.mem_addr, bus.mem_writedata, vic, ref_block(vic));
                end
            end
            if (bus.mem_read && !saw_rd) begin
                saw_rd = 1;
                checks++;
                if (bus.mem_addr !== 28'(a >> 4)) begin
                    errors++;
                    $display("FAIL refill_addr addr=%h: got %h want %h", a, bus.mem_addr, a >> 4);
                end
            end
            p_mb = bus.mem_busywait; p_rd = bus.mem_read; p_wr = bus.mem_write; p_addr = bus.mem_addr;
            n++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (n != exp_busy) begin
            errors++;
            $display("FAIL busy_cycles addr=%h wr=%0d: got %0d want %0d", a, wr, n, exp_busy);
        end
        if (!hit_e) begin
            checks++;
            if (saw_wb != dirty_e || !saw_rd) begin
                errors++;
                $display("FAIL miss_phases addr=%h: got wb=%0d rd=%0d want wb=%0d rd=1", a, saw_wb, saw_rd, dirty_e);
            end
        end
        if (!wr) begin
            checks++;
            if (bus.read_data !== ref_load(a, code)) begin
                errors++;
                $display("FAIL load addr=%h f3=%0d: got %h want %h", a, code, bus.read_data, ref_load(a, code));
            end
        end
        $display("txn %s addr=%h code=%0d wdata=%h rdata=%h busy=%0d", wr ? "ST" : "LD", a, code, wd,
                 bus.read_data, n);
        @(posedge clk);
        if (!hit_e) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
            ref_dirty[idx] = 1'b0;
        end
        if (wr) begin
            ref_dirty[idx] = 1'b1;
            h = a & ~1;
            w = a & ~3;
            case (code[1:0])
                2'b00: ref_mem[a] = wd[7:0];
                2'b01: begin ref_mem[h] = wd[7:0]; ref_mem[h+1] = wd[15:8]; end
                default: for (int i = 0; i < 4; i++) ref_mem[w+i] = wd[8*i +: 8];
            endcase
        end
        @(negedge clk);
        bus.write_ctrl = 3'b000;
        bus.read_ctrl  = 4'b0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.write_ctrl = 3'b000;
        bus.read_ctrl  = 4'b0000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_directory();
        resync_ref();
        exp_hits = 0;
        exp_misses = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.addr = '0; bus.write_data = '0; bus.write_ctrl = '0; bus.read_ctrl = '0;
        @(negedge clk);
        for (int b = 0; b < 64; b++)
            set_block(b, {$urandom, $urandom, $urandom, $urandom});
        checks++;
        if (bus.busywait !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got busy=%b rd=%b wr=%b want 0 0 0", bus.busywait, bus.mem_read, bus.mem_write);
        end
        checks++;
        if (bus.mem_addr !== '0 || bus.mem_writedata !== '0 || bus.read_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got maddr=%h mwdata=%h rdata=%h want 0", bus.mem_addr, bus.mem_writedata, bus.read_data);
        end
        checks++;
        if (bus.stat_hits !== 32'd0 || bus.stat_misses !== 32'd0) begin
            errors++;
            $display("FAIL reset_stats: got hits=%0d misses=%0d want 0 0", bus.stat_hits, bus.stat_misses);
        end
        reset = 1'b0;
        clear_directory();
        @(negedge clk);
    endtask

    task automatic test_refill();
        set_block(4, {$urandom, $urandom, $urandom, 32'hDEADBEEF});
        access(0, 32'h40, F3_LW, 0);
    endtask

    task automatic test_byte_store();
        access(1, 32'h41, {1'b0, SZ_SB}, 32'h12345680);
        access(0, 32'h41, F3_LB, 0);
        access(0, 32'h41, F3_LBU, 0);
        access(0, 32'h41, F3_LH, 0);
        access(0, 32'h43, F3_LHU, 0);
        access(0, 32'h40, 3'b011, 0);
        access(1, 32'h4B, {1'b0, SZ_SH}, 32'h0000F00D);
        access(0, 32'h49, F3_LW, 0);
    endtask

    task automatic test_writeback();
        access(0, 32'h140, F3_LW, 0);
        access(0, 32'h40, F3_LHU, 0);
    endtask

    task automatic test_slow_memory();
        lat_cfg = 5;
        access(1, 32'h144, {1'b0, SZ_SW}, $urandom);
        access(0, 32'h48, F3_LH, 0);
        access(0, 32'h2C8, F3_LW, 0);
        lat_cfg = 0;
    endtask

    task automatic test_back_to_back();
        access(0, 32'h200, F3_LW, 0);
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) access(1, 32'h200 + 4*(i/2), {1'b0, SZ_SW}, $urandom);
            else access(0, 32'h200 + 4*(i/2), F3_LW, 0);
        end
    endtask

    task automatic test_random();
        logic [2:0] rd_codes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < 300; i++) begin
            lat_cfg = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                access(1, int'($urandom_range(0, 1023)), 3'(int'($urandom_range(0, 2))), $urandom);
            else
                access(0, int'($urandom_range(0, 1023)), rd_codes[$urandom_range(0, 4)], 0);
        end
        lat_cfg = 0;
    endtask

    task automatic test_reset_mid_miss();
        int n = 0;
        access(0, 32'h80, F3_LW, 0);
        access(0, 32'h84, F3_LW, 0);
        lat_cfg = 5;
        bus.addr = 32'h300;
        bus.read_ctrl = {1'b1, F3_LW};
        #1;
        while (!bus.mem_read && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (!bus.mem_read) begin
            errors++;
            $display("FAIL alloc_reached: mem_read=%b after %0d cycles, want 1", bus.mem_read, n);
        end
        @(negedge clk);
        reset = 1'b1;
        bus.read_ctrl = 4'b0000;
        @(posedge clk);
        #1;
        checks++;
        if (bus.mem_read !== 1'b0 || bus.busywait !== 1'b0 || bus.mem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: got rd=%b wr=%b busy=%b want 0 0 0", bus.mem_read, bus.mem_write, bus.busywait);
        end
        @(negedge clk);
        reset = 1'b0;
        clear_directory();
        resync_ref();
        lat_cfg = 0;
        access(0, 32'h84, F3_LW, 0);
    endtask

    task automatic test_stats();
        logic [31:0] want_h, want_m;
        do_reset();
        access(0, 32'h00, F3_LW, 0);
        access(0, 32'h04, F3_LW, 0);
        access(1, 32'h08, {1'b0, SZ_SW}, 32'hCAFEF00D);
        access(0, 32'h10, F3_LW, 0);
        access(0, 32'h11, F3_LBU, 0);
`ifdef DCACHE_STATS_EN
        want_h = 32'(exp_hits);
        want_m = 32'(exp_misses);
`else
        want_h = 32'd0;
        want_m = 32'd0;
`endif
        checks++;
        if (bus.stat_hits !== want_h || bus.stat_misses !== want_m) begin
            errors++;
            $display("FAIL stats: got hits=%0d misses=%0d want %0d %0d", bus.stat_hits, bus.stat_misses, want_h, want_m);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_refill();
        test_byte_store();
        test_writeback();
        test_slow_memory();
        test_back_to_back();
        test_random();
        test_reset_mid_miss();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
